// File: rtl/chunk_serial_adder.sv
// Multi-cycle adder, CHUNK bits per clock, LSB chunk first; done NCH+1 cycles after accepted start.
// Starts while busy are ignored. CHUNK_SERIAL_ADDER_SUB_EN adds a sub port (z = x - y - cin).
`timescale 1ns/1ps
module chunk_serial_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
`ifdef CHUNK_SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             cout,
  output logic             ovf
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] xa_q, xa_d;
  logic [WIDTH-1:0] yb_q, yb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [31:0]      base;
  logic [CHUNK-1:0] xc, yc;
  logic [CHUNK:0]   csum;
  logic             msb_cin;
  logic             accept;

  always_comb begin
    base    = 32'(idx_q) * 32'(CHUNK);
    xc      = xa_q[base +: CHUNK];
    yc      = yb_q[base +: CHUNK];
    csum    = {1'b0, xc} + {1'b0, yc} + (CHUNK+1)'(carry_q);
    // Carry into the top bit of the chunk, recovered from its sum bit.
    msb_cin = xc[CHUNK-1] ^ yc[CHUNK-1] ^ csum[CHUNK-1];
    accept  = start && (state_q != RUN);

    state_d = state_q;
    idx_d   = idx_q;
    xa_d    = xa_q;
    yb_d    = yb_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    z_d     = z_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      RUN: begin
        acc_d[base +: CHUNK] = csum[CHUNK-1:0];
        carry_d = csum[CHUNK];
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          idx_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          z_d     = acc_d;
          cout_d  = csum[CHUNK];
          ovf_d   = msb_cin ^ csum[CHUNK];
        end
      end
      DONE:    state_d = IDLE;
      IDLE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d = RUN;
      idx_d   = '0;
      acc_d   = '0;
      busy_d  = 1'b1;
      xa_d    = x;
`ifdef CHUNK_SERIAL_ADDER_SUB_EN
      yb_d    = sub ? ~y : y;
      carry_d = sub ? ~cin : cin;
`else
      yb_d    = y;
      carry_d = cin;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      xa_q    <= '0;
      yb_q    <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      z_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      xa_q    <= xa_d;
      yb_q    <= yb_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      z_q     <= z_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign z    = z_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_chunk_serial_adder.sv
// Directed bench for chunk_serial_adder: 32/8 main instance plus 8/8 and 8/1 instances.
`timescale 1ns/1ps
module tb_chunk_serial_adder;

  logic        clk, rst;
  logic        start, cin, sub;
  logic [31:0] x, y;
  logic        busy, done, cout, ovf;
  logic [31:0] z;

  logic        start8, cin8;
  logic [7:0]  x8, y8;
  logic        busy_a, done_a, cout_a, ovf_a;
  logic [7:0]  z_a;
  logic        busy_b, done_b, cout_b, ovf_b;
  logic [7:0]  z_b;

  int checks = 0;
  int errors = 0;

  chunk_serial_adder #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .cin(cin),
`ifdef CHUNK_SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .z(z), .cout(cout), .ovf(ovf)
  );

  chunk_serial_adder #(.WIDTH(8), .CHUNK(8)) dut_a (
    .clk(clk), .rst(rst), .start(start8), .x(x8), .y(y8), .cin(cin8),
`ifdef CHUNK_SERIAL_ADDER_SUB_EN
    .sub(1'b0),
`endif
    .busy(busy_a), .done(done_a), .z(z_a), .cout(cout_a), .ovf(ovf_a)
  );

  chunk_serial_adder #(.WIDTH(8), .CHUNK(1)) dut_b (
    .clk(clk), .rst(rst), .start(start8), .x(x8), .y(y8), .cin(cin8),
`ifdef CHUNK_SERIAL_ADDER_SUB_EN
    .sub(1'b0),
`endif
    .busy(busy_b), .done(done_b), .z(z_b), .cout(cout_b), .ovf(ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        cin;
    logic        sub;
    logic [31:0] ez;
    logic        ec;
    logic        eo;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic ci,
                              input logic s, input logic [31:0] ez, input logic ec, input logic eo);
    vec_t v;
    v.x = a; v.y = b; v.cin = ci; v.sub = s; v.ez = ez; v.ec = ec; v.eo = eo;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Accept at edge k, busy for cycles k+1..k+4, done at k+5, then hold.
  task automatic run_op(input vec_t v, input string name);
    x = v.x; y = v.y; cin = v.cin; sub = v.sub; start = 1'b1;
    tick();
    start = 1'b0;
    x = $urandom; y = $urandom; cin = ~cin; sub = ~sub;
    for (int c = 1; c <= 4; c++) begin
      chk({name, " busy/done run"}, {busy, done}, 2'b10);
      tick();
    end
    chk({name, " busy/done at done"}, {busy, done}, 2'b01);
    chk({name, " z"}, z, v.ez);
    chk({name, " cout/ovf"}, {cout, ovf}, {v.ec, v.eo});
    tick();
    chk({name, " busy/done after"}, {busy, done}, 2'b00);
    chk({name, " z hold"}, z, v.ez);
  endtask

  initial begin
    logic [8:0] s8;
    logic [7:0] ez8;
    logic       ec8, eo8;
    int         lat_a, lat_b;
    logic [9:0] res_a, res_b;
    vec_t       va, vb;

    vecs.push_back(mk(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0));
    vecs.push_back(mk(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1));
    vecs.push_back(mk(32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1));
    vecs.push_back(mk(32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0));
    vecs.push_back(mk(32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0));
    vecs.push_back(mk(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0));
    vecs.push_back(mk(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0));
    vecs.push_back(mk(32'h40000000, 32'h40000000, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1));
    vecs.push_back(mk(32'h00FF00FF, 32'h00010001, 1'b1, 1'b0, 32'h01000101, 1'b0, 1'b0));
`ifdef CHUNK_SERIAL_ADDER_SUB_EN
    vecs.push_back(mk(32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0));
    vecs.push_back(mk(32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1));
    vecs.push_back(mk(32'h0000000A, 32'h00000003, 1'b0, 1'b1, 32'h00000007, 1'b1, 1'b0));
    vecs.push_back(mk(32'h00000005, 32'h00000005, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0));
`endif

    rst = 1'b1; start = 1'b0; x = '0; y = '0; cin = 1'b0; sub = 1'b0;
    start8 = 1'b0; x8 = '0; y8 = '0; cin8 = 1'b0;
    tick(); tick();
    chk("reset outputs", {busy, done, cout, ovf}, 4'b0000);
    chk("reset z", z, 32'h0);
    rst = 1'b0;
    tick();
    chk("idle outputs", {busy, done}, 2'b00);

    foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));

    // Start while busy is ignored; start in the DONE cycle is accepted.
    va = mk(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
    vb = mk(32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0);
    x = va.x; y = va.y; cin = va.cin; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; x = 32'hDEADBEEF;
    tick();
    x = vb.x; y = vb.y; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("ignored start busy", {busy, done}, 2'b10);
    tick(); tick();
    chk("b2b first done", {busy, done}, 2'b01);
    chk("b2b first z", {cout, ovf, z}, {va.ec, va.eo, va.ez});
    x = vb.x; y = vb.y; cin = vb.cin; start = 1'b1;
    tick();
    start = 1'b0; x = '0; y = '0;
    for (int c = 6; c <= 9; c++) begin
      chk("b2b second running", {busy, done}, 2'b10);
      chk("b2b result held", {cout, ovf, z}, {va.ec, va.eo, va.ez});
      tick();
    end
    chk("b2b second done", {busy, done}, 2'b01);
    chk("b2b second z", {cout, ovf, z}, {vb.ec, vb.eo, vb.ez});
    tick();

    // Reset mid-run aborts and clears outputs.
    x = 32'h00000001; y = 32'h00000001; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort outputs", {busy, done, cout, ovf}, 4'b0000);
    chk("abort z", z, 32'h0);
    for (int c = 0; c < 4; c++) begin
      chk("abort no done", {busy, done}, 2'b00);
      tick();
    end
    run_op(mk(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1), "post-abort");

    // 8-bit builds: CHUNK==WIDTH (latency 2) and bit-serial (latency 9).
    for (int op = 0; op < 300; op++) begin
      case (op)
        0: begin x8 = 8'hFF; y8 = 8'h01; cin8 = 1'b0; end
        1: begin x8 = 8'h7F; y8 = 8'h01; cin8 = 1'b0; end
        2: begin x8 = 8'h80; y8 = 8'h80; cin8 = 1'b0; end
        3: begin x8 = 8'hFF; y8 = 8'hFF; cin8 = 1'b1; end
        default: begin x8 = 8'($urandom); y8 = 8'($urandom); cin8 = 1'($urandom); end
      endcase
      s8  = {1'b0, x8} + {1'b0, y8} + 9'(cin8);
      ez8 = s8[7:0];
      ec8 = s8[8];
      eo8 = (x8[7] == y8[7]) && (ez8[7] != x8[7]);
      start8 = 1'b1;
      tick();
      start8 = 1'b0; x8 = 8'($urandom); y8 = 8'($urandom); cin8 = ~cin8;
      lat_a = 0; lat_b = 0; res_a = '0; res_b = '0;
      for (int c = 1; c <= 11; c++) begin
        if (done_a && lat_a == 0) begin lat_a = c; res_a = {cout_a, ovf_a, z_a}; end
        if (done_b && lat_b == 0) begin lat_b = c; res_b = {cout_b, ovf_b, z_b}; end
        if (c == 1) chk("w8 busy first cycle", {busy_a, busy_b}, 2'b11);
        tick();
      end
      chk($sformatf("w8c8 latency op%0d", op), 64'(lat_a), 64'd2);
      chk($sformatf("w8c1 latency op%0d", op), 64'(lat_b), 64'd9);
      chk($sformatf("w8c8 result op%0d", op), res_a, {ec8, eo8, ez8});
      chk($sformatf("w8c1 result op%0d", op), res_b, {ec8, eo8, ez8});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
